// File: rtl/countdown_ctrl.sv
// countdown_ctrl: keypad-driven BCD preset entry, 1 Hz countdown and timed alarm sequencer
module countdown_ctrl #(
    parameter int NDIG        = 4,
    parameter int ALARM_TICKS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                keydown_start,
    input  logic                keydown_confirm,
    input  logic                keydown_clear,
    input  logic                keydown_num,
    input  logic [3:0]          num,
    output logic [4*NDIG-1:0]   digits,
    output logic [2:0]          state,
    output logic                running,
    output logic                alarm,
    output logic                done
);
    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        ARMED = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        ALARM = 3'd5
    } state_t;

    state_t             st;
    logic [4*NDIG-1:0]  preset;
    logic [4*NDIG-1:0]  dec;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      timer;
    logic               borrow;
    logic               any_key;

    assign state   = st;
    assign any_key = keydown_start | keydown_confirm | keydown_clear | keydown_num;

    // BCD decrement: a zero digit wraps to 9 and passes the borrow upward
    always_comb begin
        dec    = digits;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (digits[4*i +: 4] == 4'd0) begin
                    dec[4*i +: 4] = 4'd9;
                end else begin
                    dec[4*i +: 4] = digits[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
    end

    // Sequencer: state plus all registered outputs; running/alarm follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            digits  <= '0;
            preset  <= '0;
            cnt     <= '0;
            timer   <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (keydown_num) begin
                        digits <= {{(4*NDIG-4){1'b0}}, num};
                        cnt    <= CW'(1);
                        st     <= ENTRY;
                    end else if (keydown_confirm && preset != '0) begin
                        digits <= preset;
                        st     <= ARMED;
                    end
                end
                ENTRY: begin
                    if (keydown_num) begin
                        if (cnt < CW'(NDIG)) begin
                            digits <= {digits[4*NDIG-5:0], num};
                            cnt    <= cnt + CW'(1);
                        end
                    end else if (keydown_confirm) begin
                        cnt <= '0;
                        if (digits != '0) begin
                            preset <= digits;
                            st     <= ARMED;
                        end else begin
                            st <= IDLE;
                        end
                    end else if (keydown_clear) begin
                        digits <= '0;
                        cnt    <= '0;
                        st     <= IDLE;
                    end
                end
                ARMED: begin
                    if (keydown_start) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end else if (keydown_clear) begin
                        digits <= '0;
                        st     <= IDLE;
                    end
                end
                RUN: begin
                    if (keydown_clear) begin
                        digits  <= '0;
                        st      <= IDLE;
                        running <= 1'b0;
                    end else if (keydown_start) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                    end else if (tick && digits != '0) begin
                        digits <= dec;
                        if (dec == '0) begin
                            st      <= ALARM;
                            running <= 1'b0;
                            alarm   <= 1'b1;
                            done    <= 1'b1;
                            timer   <= TW'(ALARM_TICKS);
                        end
                    end
                end
                PAUSE: begin
                    if (keydown_start) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end else if (keydown_clear) begin
                        digits <= '0;
                        st     <= IDLE;
                    end
                end
                ALARM: begin
                    if (any_key) begin
                        timer <= '0;
                        st    <= IDLE;
                        alarm <= 1'b0;
                    end else if (tick) begin
                        timer <= timer - TW'(1);
                        if (timer <= TW'(1)) begin
                            st    <= IDLE;
                            alarm <= 1'b0;
                        end
                    end
                end
                default: begin
                    st      <= IDLE;
                    running <= 1'b0;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed scenario tests for the countdown sequencer
module tb_countdown_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_ARMED = 3'd2,
                           S_RUN = 3'd3, S_PAUSE = 3'd4, S_ALARM = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, keydown_start = 1'b0, keydown_confirm = 1'b0;
    logic        keydown_clear = 1'b0, keydown_num = 1'b0;
    logic [3:0]  num = 4'd0;
    logic [15:0] digits;
    logic [2:0]  state;
    logic        running, alarm, done;
    int          checks = 0;
    int          errors = 0;

    countdown_ctrl #(.NDIG(4), .ALARM_TICKS(5)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .keydown_start(keydown_start), .keydown_confirm(keydown_confirm),
        .keydown_clear(keydown_clear), .keydown_num(keydown_num), .num(num),
        .digits(digits), .state(state), .running(running), .alarm(alarm), .done(done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs starting at a falling edge, end at the next falling edge
    task automatic drive(input logic s, input logic c, input logic cl, input logic n,
                         input logic t, input logic [3:0] d);
        keydown_start = s; keydown_confirm = c; keydown_clear = cl;
        keydown_num = n; tick = t; num = d;
        @(negedge clk);
        keydown_start = 0; keydown_confirm = 0; keydown_clear = 0;
        keydown_num = 0; tick = 0; num = 0;
    endtask

    task automatic key_num(input logic [3:0] d); drive(0, 0, 0, 1, 0, d); endtask
    task automatic key_start;   drive(1, 0, 0, 0, 0, 4'd0); endtask
    task automatic key_confirm; drive(0, 1, 0, 0, 0, 4'd0); endtask
    task automatic key_clear;   drive(0, 0, 1, 0, 0, 4'd0); endtask
    task automatic one_tick;    drive(0, 0, 0, 0, 1, 4'd0); endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic test_reset;
        do_reset();
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", digits); end
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        checks++; if ({running, alarm, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {running, alarm, done}); end
    endtask

    task automatic test_entry;
        key_num(4'd1);
        checks++; if (digits !== 16'h0001 || state !== S_ENTRY) begin errors++; $display("FAIL entry_first: got %h/%0d expected 0001/%0d", digits, state, S_ENTRY); end
        key_num(4'd2);
        key_confirm();
        checks++; if (digits !== 16'h0012) begin errors++; $display("FAIL entry_digits: got %h expected 0012", digits); end
        checks++; if (state !== S_ARMED) begin errors++; $display("FAIL entry_armed: got %0d expected %0d", state, S_ARMED); end
    endtask

    task automatic test_countdown;
        key_start();
        checks++; if (state !== S_RUN || running !== 1'b1) begin errors++; $display("FAIL run_start: got %0d/%b expected %0d/1", state, running, S_RUN); end
        for (int k = 1; k <= 12; k++) begin
            one_tick();
            checks++; if (digits !== bcd(12 - k)) begin errors++; $display("FAIL count_digits[%0d]: got %h expected %h", k, digits, bcd(12 - k)); end
            if (k < 12) begin
                checks++; if (state !== S_RUN || done !== 1'b0) begin errors++; $display("FAIL count_run[%0d]: got %0d/%b expected %0d/0", k, state, done, S_RUN); end
            end
        end
        checks++; if ({state, alarm, done, running} !== {S_ALARM, 3'b110}) begin errors++; $display("FAIL zero_alarm: got %0d/%b%b%b expected %0d/110", state, alarm, done, running, S_ALARM); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || alarm !== 1'b1) begin errors++; $display("FAIL done_one_cycle: got done=%b alarm=%b expected 0/1", done, alarm); end
        for (int k = 1; k <= 4; k++) begin
            one_tick();
            checks++; if (state !== S_ALARM || digits !== 16'h0000) begin errors++; $display("FAIL alarm_hold[%0d]: got %0d/%h expected %0d/0000", k, state, digits, S_ALARM); end
        end
        one_tick();
        checks++; if (state !== S_IDLE || alarm !== 1'b0) begin errors++; $display("FAIL alarm_expire: got %0d/%b expected %0d/0", state, alarm, S_IDLE); end
        key_confirm();
        checks++; if (state !== S_ARMED || digits !== 16'h0012) begin errors++; $display("FAIL preset_kept: got %0d/%h expected %0d/0012", state, digits, S_ARMED); end
        key_clear();
        checks++; if (state !== S_IDLE || digits !== 16'h0000) begin errors++; $display("FAIL armed_clear: got %0d/%h expected %0d/0000", state, digits, S_IDLE); end
    endtask

    task automatic test_borrow;
        key_num(4'd1); key_num(4'd0); key_num(4'd0);
        checks++; if (digits !== 16'h0100) begin errors++; $display("FAIL entry_zeros: got %h expected 0100", digits); end
        key_confirm(); key_start(); one_tick();
        checks++; if (digits !== 16'h0099) begin errors++; $display("FAIL borrow_100: got %h expected 0099", digits); end
        key_clear();
        key_num(4'd1); key_num(4'd0); key_num(4'd0); key_num(4'd0);
        key_confirm(); key_start(); one_tick();
        checks++; if (digits !== 16'h0999) begin errors++; $display("FAIL borrow_1000: got %h expected 0999", digits); end
        key_clear();
    endtask

    task automatic test_entry_limit;
        do_reset();
        key_num(4'd0);
        key_confirm();
        checks++; if (state !== S_IDLE || digits !== 16'h0000) begin errors++; $display("FAIL zero_confirm: got %0d/%h expected %0d/0000", state, digits, S_IDLE); end
        key_confirm();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL idle_confirm_nopreset: got %0d expected %0d", state, S_IDLE); end
        key_num(4'd1); key_num(4'd2); key_num(4'd3); key_num(4'd4); key_num(4'd5);
        checks++; if (digits !== 16'h1234 || state !== S_ENTRY) begin errors++; $display("FAIL entry_full: got %h/%0d expected 1234/%0d", digits, state, S_ENTRY); end
        key_clear();
        checks++; if (digits !== 16'h0000 || state !== S_IDLE) begin errors++; $display("FAIL entry_clear: got %h/%0d expected 0000/%0d", digits, state, S_IDLE); end
    endtask

    task automatic test_pause;
        key_num(4'd3); key_num(4'd0); key_confirm(); key_start();
        key_start();
        checks++; if (state !== S_PAUSE || running !== 1'b0) begin errors++; $display("FAIL pause_enter: got %0d/%b expected %0d/0", state, running, S_PAUSE); end
        repeat (3) one_tick();
        checks++; if (digits !== 16'h0030 || state !== S_PAUSE) begin errors++; $display("FAIL pause_hold: got %h/%0d expected 0030/%0d", digits, state, S_PAUSE); end
        key_start();
        checks++; if (state !== S_RUN || running !== 1'b1) begin errors++; $display("FAIL pause_resume: got %0d/%b expected %0d/1", state, running, S_RUN); end
        drive(1, 0, 0, 0, 1, 4'd0);
        checks++; if (state !== S_PAUSE || digits !== 16'h0030) begin errors++; $display("FAIL start_beats_tick: got %0d/%h expected %0d/0030", state, digits, S_PAUSE); end
        key_start(); one_tick();
        checks++; if (digits !== 16'h0029) begin errors++; $display("FAIL resume_tick: got %h expected 0029", digits); end
        drive(0, 0, 1, 0, 1, 4'd0);
        checks++; if (state !== S_IDLE || digits !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL clear_beats_tick: got %0d/%h/%b expected %0d/0000/0", state, digits, running, S_IDLE); end
    endtask

    task automatic test_clear_and_reset;
        key_num(4'd1); key_num(4'd2); key_confirm(); key_start();
        repeat (5) one_tick();
        checks++; if (digits !== 16'h0007) begin errors++; $display("FAIL run_at_7: got %h expected 0007", digits); end
        key_clear();
        checks++; if (state !== S_IDLE || digits !== 16'h0000) begin errors++; $display("FAIL run_clear: got %0d/%h expected %0d/0000", state, digits, S_IDLE); end
        key_confirm();
        checks++; if (state !== S_ARMED || digits !== 16'h0012) begin errors++; $display("FAIL reload_preset: got %0d/%h expected %0d/0012", state, digits, S_ARMED); end
        key_start(); one_tick();
        do_reset();
        checks++; if (state !== S_IDLE || digits !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL run_reset: got %0d/%h/%b expected %0d/0000/0", state, digits, running, S_IDLE); end
        key_confirm();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_preset: got %0d expected %0d", state, S_IDLE); end
    endtask

    task automatic test_alarm_key;
        key_num(4'd1); key_confirm(); key_start(); one_tick();
        checks++; if (state !== S_ALARM || done !== 1'b1 || digits !== 16'h0000) begin errors++; $display("FAIL alarm_from_1: got %0d/%b/%h expected %0d/1/0000", state, done, digits, S_ALARM); end
        key_num(4'd7);
        checks++; if (state !== S_IDLE || alarm !== 1'b0 || digits !== 16'h0000) begin errors++; $display("FAIL alarm_key_exit: got %0d/%b/%h expected %0d/0/0000", state, alarm, digits, S_IDLE); end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_countdown();
        test_borrow();
        test_entry_limit();
        test_pause();
        test_clear_and_reset();
        test_alarm_key();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
